present_core: RTL
=================

Name: present_core

Overview:
- Parametrised PRESENT block-cipher engine with one round per cycle.
- Supports 80- or 128-bit keys, and both encryption and decryption.
- Uses valid/ready handshakes on input and output.
- Successor to the fixed PRESENT-80 encrypt-only core. Sits between the bus-side command FIFO and the result buffer of the crypto accelerator.

Parameters:
- KEY_W, 80, key length; legal values are 80 or 128, anything else is an elaboration error.
- DEC_EN, 1, 1 builds the decrypt datapath and inverse key schedule; 0 gives an encrypt-only core.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  core can accept a request
- in_mode  in  1  0 = encrypt, 1 = decrypt
- in_key  in  KEY_W  cipher key
- in_data  in  64  plaintext or ciphertext
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_data  out  64  result block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1; out_valid=0; out_data=0; busy=0.
- Reset clears the state register, key register, round counter (rc) and FSM to IDLE.
- Reset mid-operation aborts the operation. No output is produced.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- in_ready = (fsm==IDLE); requests are never accepted in other states.
- IDLE, on in_valid & in_ready:
  - latch in_data into state, in_key into key, in_mode into mode; set rc=1.
  - Encrypt goes to ROUND.
  - Decrypt goes to KEYEXP.
  - in_mode=1 with DEC_EN=0 is executed as encrypt.
- KEYEXP (decrypt only):
  - each cycle key <= fwd_sched(key, rc); rc++.
  - After 31 cycles key holds K32; rc resets to 31 and the FSM goes to ROUND.
  - The state register does not toggle in KEYEXP (low-power requirement).
- ROUND, encrypt, rc = 1..31:
  - state <= P(S(state ^ K_rc)); key <= fwd_sched(key, rc); rc++.
  - On rc==31: out_data <= P(S(state ^ K31)) ^ K32; out_valid <= 1; go to DONE.
- ROUND, decrypt, rc = 31..1:
  - state <= Sinv(Pinv(state ^ K_(rc+1))); key <= inv_sched(key, rc); rc--.
  - On rc==1: out_data <= Sinv(Pinv(state ^ K2)) ^ K1; go to DONE.
- Round key K_i is always key[KEY_W-1 -: 64].
- fwd_sched, 80-bit key:
  - rotate left 61;
  - S-box on bits [79:76];
  - XOR rc into bits [19:15].
- fwd_sched, 128-bit key:
  - rotate left 61;
  - S-box on bits [127:124] and [123:120];
  - XOR rc into bits [66:62].
- inv_sched is the exact inverse of fwd_sched:
  - XOR rc into the same bits;
  - inverse S-box on the same nibbles;
  - rotate right 61.
- rc is 5 bits wide and never wraps during an operation.
- Latency: accept edge to out_valid is 31 cycles for encrypt and 62 cycles for decrypt.
- DONE:
  - out_valid and out_data are held stable until out_ready.
  - On the out_valid & out_ready edge: out_valid <= 0; key and state registers are zeroised; go to IDLE.
  - in_ready rises the cycle after that edge; there is no back-to-back accept in the same cycle.
- in_valid is ignored whenever busy. The input port has no buffering.

Decomposition:
- present_pkg holds:
  - the S-box and inverse S-box functions;
  - the P-layer and inverse P-layer functions, using the rule bit i moves to 16*i mod 63, with bit 63 fixed;
  - the FSM state enum;
  - the ROUNDS=31 constant;
  - localparam tables for the counter-XOR bit positions per KEY_W.
- One sub-module, present_key_sched. It is combinational and parametrised by KEY_W, with inputs key, rc and dir and output next_key. It is instantiated once; the core muxes its direction.

Test Plan:
- KEY_W=80, encrypt, key=0, pt=0 -> out_data=5579C1387B228445, out_valid rises exactly 31 cycles after accept.
- KEY_W=80, encrypt, key=all-ones, pt=all-ones -> 3333DCD3213210D2. Then decrypt of that ciphertext with the same key -> all-ones, with latency 62 cycles.
- KEY_W=128, encrypt, key=0, pt=0 -> 96DB702A2E6900AF. Then decrypt round-trip returns 0.
- Backpressure: hold out_ready=0 for 20 cycles after a result.
  - out_data stays stable and in_ready stays 0.
  - A new in_valid pulse during this time is ignored.
  - The result is released on the first out_ready edge.
- Reset asserted in the 10th round cycle -> next cycle out_valid=0, busy=0, in_ready=1 after reset deasserts. A fresh key=0/pt=0 request then yields 5579C1387B228445.
- DEC_EN=0 build, in_mode=1, key=all-ones, pt=0 -> encrypt result E72C46C0F5945049 after 31 cycles.

Source files
------------

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : present_pkg
//  Description : Shared definitions for the PRESENT cipher core: S-box and
//                P-layer helpers (forward and inverse), FSM state type,
//                round count and round-counter injection positions.
//  Revision    : 1.0 - initial parametrised 80/128-bit enc/dec release
// ============================================================================
package present_pkg;

    localparam logic [4:0] ROUNDS = 5'd31;

    // Bit position where the round counter is XORed into the key register.
    localparam int RC_LSB_80  = 15;
    localparam int RC_LSB_128 = 62;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Nibble n of each table holds S(n) / Sinv(n).
    localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV_TBL = 64'hA970364BD21C8FE5;

    function automatic int rc_lsb(input int key_w);
        return (key_w == 128) ? RC_LSB_128 : RC_LSB_80;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4 * n) +: 4] = sbox(x[6'(4 * n) +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4 * n) +: 4] = sbox_inv(x[6'(4 * n) +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays in place.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'((16 * i) % 63)] = x[6'(i)];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] p_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'(i)] = x[6'((16 * i) % 63)];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : present_key_sched
//  Description : Combinational PRESENT key-schedule step, forward or inverse.
//  Ports       : key      - current key register
//                rc       - round counter value for this step
//                dir      - 0 = forward schedule, 1 = inverse schedule
//                next_key - updated key register
//  Revision    : 1.0 - initial release
// ============================================================================
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    input  logic             dir,
    output logic [KEY_W-1:0] next_key
);

    localparam int RC_LSB = rc_lsb(KEY_W);

    logic [KEY_W-1:0] w_fwd;
    logic [KEY_W-1:0] w_inv_pre;
    logic [KEY_W-1:0] w_inv;

    always_comb begin
        // Forward: rotate left 61, substitute top nibble(s), inject counter.
        w_fwd = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};
        w_fwd[KEY_W-1 -: 4] = sbox(w_fwd[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            w_fwd[KEY_W-5 -: 4] = sbox(w_fwd[KEY_W-5 -: 4]);
        end
        w_fwd[RC_LSB +: 5] = w_fwd[RC_LSB +: 5] ^ rc;

        // Inverse: undo the forward steps in reverse order.
        w_inv_pre = key;
        w_inv_pre[RC_LSB +: 5] = w_inv_pre[RC_LSB +: 5] ^ rc;
        w_inv_pre[KEY_W-1 -: 4] = sbox_inv(w_inv_pre[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            w_inv_pre[KEY_W-5 -: 4] = sbox_inv(w_inv_pre[KEY_W-5 -: 4]);
        end
        w_inv = {w_inv_pre[60:0], w_inv_pre[KEY_W-1:61]};
    end

    assign next_key = dir ? w_inv : w_fwd;

endmodule
`default_nettype wire

// File: rtl/present_core.sv
`default_nettype none
// ============================================================================
//  Module      : present_core
//  Description : PRESENT block cipher, one round per cycle, 80/128-bit key,
//                optional decryption, valid/ready on both sides.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                in_valid/in_ready     - request handshake
//                in_mode               - 0 encrypt, 1 decrypt
//                in_key/in_data        - key and 64-bit block
//                out_valid/out_ready   - result handshake
//                out_data              - 64-bit result
//                busy                  - core not idle
//  Revision    : 1.0 - successor of fixed PRESENT-80 encrypt-only core
// ============================================================================
module present_core
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int DEC_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [KEY_W-1:0] in_key,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy
);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_core: KEY_W must be 80 or 128");
    end

    state_t           r_fsm;
    state_t           w_fsm_next;
    logic [63:0]      r_state;
    logic [KEY_W-1:0] r_key;
    logic [4:0]       r_rc;
    logic             r_mode;
    logic [63:0]      r_out_data;
    logic             r_out_valid;

    logic             w_dec_mode;
    logic             w_start_dec;
    logic             w_key_dir;
    logic [KEY_W-1:0] w_next_key;
    logic [63:0]      w_rk;
    logic [63:0]      w_nk;
    logic [63:0]      w_mix;
    logic [63:0]      w_round;
    logic             w_last;

    // Gating with DEC_EN lets the decrypt path fold away in encrypt-only builds.
    assign w_dec_mode  = (DEC_EN != 0) && r_mode;
    assign w_start_dec = (DEC_EN != 0) && in_mode;
    // KEYEXP walks forward to K32; only decrypt rounds step the key backwards.
    assign w_key_dir   = (r_fsm == ST_ROUND) && w_dec_mode;

    present_key_sched #(
        .KEY_W    (KEY_W)
    ) u_key_sched (
        .key      (r_key),
        .rc       (r_rc),
        .dir      (w_key_dir),
        .next_key (w_next_key)
    );

    assign w_rk    = r_key[KEY_W-1 -: 64];
    assign w_nk    = w_next_key[KEY_W-1 -: 64];
    assign w_mix   = r_state ^ w_rk;
    assign w_round = w_dec_mode ? s_inv_layer(p_inv_layer(w_mix))
                                : p_layer(s_layer(w_mix));
    assign w_last  = w_dec_mode ? (r_rc == 5'd1) : (r_rc == ROUNDS);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:   if (in_valid) w_fsm_next = w_start_dec ? ST_KEYEXP : ST_ROUND;
            ST_KEYEXP: if (r_rc == ROUNDS) w_fsm_next = ST_ROUND;
            ST_ROUND:  if (w_last) w_fsm_next = ST_DONE;
            ST_DONE:   if (out_ready) w_fsm_next = ST_IDLE;
            default:   w_fsm_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = (r_fsm == ST_IDLE) && !reset;
        busy      = (r_fsm != ST_IDLE);
        out_valid = r_out_valid;
        out_data  = r_out_data;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= '0;
            r_key       <= '0;
            r_rc        <= '0;
            r_mode      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_key   <= in_key;
                        r_mode  <= w_start_dec;
                        r_rc    <= 5'd1;
                    end
                end
                ST_KEYEXP: begin
                    // State register deliberately left untouched here.
                    r_key <= w_next_key;
                    r_rc  <= (r_rc == ROUNDS) ? ROUNDS : r_rc + 5'd1;
                end
                ST_ROUND: begin
                    r_state <= w_round;
                    r_key   <= w_next_key;
                    if (w_last) begin
                        // w_nk is K32 (encrypt) or K1 (decrypt): final whitening.
                        r_out_data  <= w_round ^ w_nk;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rc <= w_dec_mode ? r_rc - 5'd1 : r_rc + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_key       <= '0;
                        r_state     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
